// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory combinationally and
// loads the IF/ID pipeline register, with stall, redirect, halt and fault handling.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0040_0404,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic [31:0] imem_instr,
  output logic [31:0] curr_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_d, instr_d, ifid_pc_d, ifid_pc_plus4_d, count_d;
  logic              valid_d, fault_d;
  logic              illegal;

  // Fetch address legality: word aligned and inside the instruction memory window.
  assign illegal = (curr_pc[1:0] != 2'b00) || (curr_pc < IMEM_BASE) || (curr_pc >= IMEM_LIMIT);

  // Next-state and next-register values; priority redirect > illegal > halt > stall > fetch.
  always_comb begin
    state_d         = state_q;
    pc_d            = curr_pc;
    instr_d         = ifid_instr;
    ifid_pc_d       = ifid_pc;
    ifid_pc_plus4_d = ifid_pc_plus4;
    valid_d         = ifid_valid;
    fault_d         = fetch_fault;
    count_d         = fetch_count;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (illegal) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (halt_req) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d         = imem_instr;
          ifid_pc_d       = curr_pc;
          ifid_pc_plus4_d = curr_pc + XLEN'(4);
          valid_d         = 1'b1;
          pc_d            = curr_pc + XLEN'(4);
          count_d         = (fetch_count == '1) ? fetch_count : fetch_count + XLEN'(1);
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          state_d = RUN;
          pc_d    = redirect_pc;
        end
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        // Unused encoding: park in the terminal fault state.
        state_d = FAULT;
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= RUN;
      curr_pc       <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      fetch_fault   <= 1'b0;
      fetch_count   <= '0;
    end else begin
      state_q       <= state_d;
      curr_pc       <= pc_d;
      ifid_instr    <= instr_d;
      ifid_pc       <= ifid_pc_d;
      ifid_pc_plus4 <= ifid_pc_plus4_d;
      ifid_valid    <= valid_d;
      fetch_fault   <= fault_d;
      fetch_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_instr;
  logic [31:0] curr_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_instr     (imem_instr),
    .curr_pc        (curr_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_valid     (ifid_valid),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory model: three program words at the base, a pc-derived pattern elsewhere.
  always_comb begin
    case (curr_pc)
      32'h0040_0000: imem_instr = 32'h2008_0005;
      32'h0040_0004: imem_instr = 32'h2009_0003;
      32'h0040_0008: imem_instr = 32'h0109_5020;
      default:       imem_instr = curr_pc ^ 32'hA5A5_0000;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    idle_inputs();
    step();
    do_reset();
    checks++;
    if (curr_pc !== 32'h0040_0000 || ifid_valid !== 1'b0 || fetch_count !== 32'd0 ||
        fetch_fault !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL reset: pc=%h valid=%b cnt=%0d fault=%b instr=%h ipc=%h ip4=%h, required pc=00400000 all others 0",
               curr_pc, ifid_valid, fetch_count, fetch_fault, ifid_instr, ifid_pc, ifid_pc_plus4);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc[0] = 32'h0040_0000; exp_pc[1] = 32'h0040_0004; exp_pc[2] = 32'h0040_0008;
    exp_in[0] = 32'h2008_0005; exp_in[1] = 32'h2009_0003; exp_in[2] = 32'h0109_5020;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ifid_pc !== exp_pc[i] || ifid_instr !== exp_in[i] || ifid_valid !== 1'b1 ||
          ifid_pc_plus4 !== exp_pc[i] + 32'd4 || fetch_count !== 32'(i + 1)) begin
        failures++;
        $display("FAIL free_run[%0d]: ipc=%h instr=%h valid=%b ip4=%h cnt=%0d, required ipc=%h instr=%h valid=1 ip4=%h cnt=%0d",
                 i, ifid_pc, ifid_instr, ifid_valid, ifid_pc_plus4, fetch_count,
                 exp_pc[i], exp_in[i], exp_pc[i] + 32'd4, i + 1);
      end
    end
    checks++;
    if (curr_pc !== 32'h0040_000C) begin
      failures++;
      $display("FAIL free_run_pc: curr_pc=%h required 0040000c", curr_pc);
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ifid_pc !== 32'h0040_0000 || curr_pc !== 32'h0040_0004 || fetch_count !== 32'd1 ||
          ifid_valid !== 1'b1 || ifid_instr !== 32'h2008_0005) begin
        failures++;
        $display("FAIL stall[%0d]: ipc=%h pc=%h cnt=%0d valid=%b instr=%h, required ipc=00400000 pc=00400004 cnt=1 valid=1 instr=20080005",
                 i, ifid_pc, curr_pc, fetch_count, ifid_valid, ifid_instr);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0040;
    step();
    checks++;
    if (ifid_valid !== 1'b0 || curr_pc !== 32'h0040_0040 || ifid_instr !== 32'h0 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL redirect_flush: valid=%b pc=%h instr=%h cnt=%0d, required valid=0 pc=00400040 instr=0 cnt=1",
               ifid_valid, curr_pc, ifid_instr, fetch_count);
    end
    idle_inputs();
    step();
    checks++;
    if (ifid_pc !== 32'h0040_0040 || ifid_instr !== 32'hA5E5_0040 || ifid_valid !== 1'b1 ||
        curr_pc !== 32'h0040_0044 || fetch_count !== 32'd2) begin
      failures++;
      $display("FAIL redirect_fetch: ipc=%h instr=%h valid=%b pc=%h cnt=%0d, required ipc=00400040 instr=a5e50040 valid=1 pc=00400044 cnt=2",
               ifid_pc, ifid_instr, ifid_valid, curr_pc, fetch_count);
    end
  endtask

  task automatic test_redirect_fault();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0402;
    step();
    checks++;
    if (ifid_valid !== 1'b0 || fetch_fault !== 1'b0 || curr_pc !== 32'h0040_0402) begin
      failures++;
      $display("FAIL misalign_accept: valid=%b fault=%b pc=%h, required valid=0 fault=0 pc=00400402",
               ifid_valid, fetch_fault, curr_pc);
    end
    idle_inputs();
    step();
    checks++;
    if (fetch_fault !== 1'b1 || ifid_valid !== 1'b0 || curr_pc !== 32'h0040_0402 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL misalign_fault: fault=%b valid=%b pc=%h cnt=%0d, required fault=1 valid=0 pc=00400402 cnt=0",
               fetch_fault, ifid_valid, curr_pc, fetch_count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      redirect_valid = (i == 0) ? 1'b0 : 1'b1;
      checks++;
      if (fetch_fault !== 1'b1 || ifid_valid !== 1'b0 || curr_pc !== 32'h0040_0402 || fetch_count !== 32'd0) begin
        failures++;
        $display("FAIL fault_frozen[%0d]: fault=%b valid=%b pc=%h cnt=%0d, required fault=1 valid=0 pc=00400402 cnt=0",
                 i, fetch_fault, ifid_valid, curr_pc, fetch_count);
      end
    end
  endtask

  task automatic test_limit_fault();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0400;
    step();
    idle_inputs();
    step();
    checks++;
    if (ifid_pc !== 32'h0040_0400 || ifid_instr !== 32'hA5E5_0400 || ifid_valid !== 1'b1 ||
        curr_pc !== 32'h0040_0404 || fetch_fault !== 1'b0 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL last_word: ipc=%h instr=%h valid=%b pc=%h fault=%b cnt=%0d, required ipc=00400400 instr=a5e50400 valid=1 pc=00400404 fault=0 cnt=1",
               ifid_pc, ifid_instr, ifid_valid, curr_pc, fetch_fault, fetch_count);
    end
    step();
    checks++;
    if (fetch_fault !== 1'b1 || ifid_valid !== 1'b0 || curr_pc !== 32'h0040_0404 ||
        ifid_pc !== 32'h0040_0400 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL limit_fault: fault=%b valid=%b pc=%h ipc=%h cnt=%0d, required fault=1 valid=0 pc=00400404 ipc=00400400 cnt=1",
               fetch_fault, ifid_valid, curr_pc, ifid_pc, fetch_count);
    end
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h003F_FFFC;
    step();
    idle_inputs();
    step();
    checks++;
    if (fetch_fault !== 1'b1 || curr_pc !== 32'h003F_FFFC || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL below_base: fault=%b pc=%h cnt=%0d, required fault=1 pc=003ffffc cnt=0",
               fetch_fault, curr_pc, fetch_count);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    halt_req = 1'b1;
    step();
    checks++;
    if (ifid_valid !== 1'b0 || curr_pc !== 32'h0040_0010 || fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL halt_enter: valid=%b pc=%h cnt=%0d, required valid=0 pc=00400010 cnt=4",
               ifid_valid, curr_pc, fetch_count);
    end
    for (int i = 0; i < 10; i++) begin
      halt_req = i[0];
      stall = i[1];
      step();
      checks++;
      if (ifid_valid !== 1'b0 || curr_pc !== 32'h0040_0010 || fetch_count !== 32'd4 || fetch_fault !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold[%0d]: valid=%b pc=%h cnt=%0d fault=%b, required valid=0 pc=00400010 cnt=4 fault=0",
                 i, ifid_valid, curr_pc, fetch_count, fetch_fault);
      end
    end
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
    step();
    checks++;
    if (curr_pc !== 32'h0040_0000 || ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume: pc=%h valid=%b, required pc=00400000 valid=0", curr_pc, ifid_valid);
    end
    idle_inputs();
    step();
    checks++;
    if (ifid_pc !== 32'h0040_0000 || ifid_instr !== 32'h2008_0005 || ifid_valid !== 1'b1 ||
        fetch_count !== 32'd5 || curr_pc !== 32'h0040_0004) begin
      failures++;
      $display("FAIL resume_fetch: ipc=%h instr=%h valid=%b cnt=%0d pc=%h, required ipc=00400000 instr=20080005 valid=1 cnt=5 pc=00400004",
               ifid_pc, ifid_instr, ifid_valid, fetch_count, curr_pc);
    end
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if (curr_pc !== 32'h0040_0000 || ifid_valid !== 1'b0 || fetch_count !== 32'd0 ||
        ifid_instr !== 32'h0 || ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: pc=%h valid=%b cnt=%0d instr=%h ipc=%h ip4=%h, required pc=00400000 others 0",
               curr_pc, ifid_valid, fetch_count, ifid_instr, ifid_pc, ifid_pc_plus4);
    end
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_redirect();
    test_redirect_fault();
    test_limit_fault();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
